// File: rtl/ex_muldiv_pkg.sv
// ----------------------------------------------------------------------------
// ex_muldiv_pkg : shared bus types, ALU opcodes and helpers for the EX stage
// Revision      : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package ex_muldiv_pkg;

  typedef logic [31:0] RegBus;
  typedef logic [7:0]  AluOpBus;
  typedef logic [63:0] DoubleRegBus;

  localparam logic RstEnable = 1'b1;
  localparam logic Stop      = 1'b1;
  localparam logic NoStop    = 1'b0;

  localparam AluOpBus EXE_NOP_OP   = 8'b0000_0000;
  localparam AluOpBus EXE_MULT_OP  = 8'b0001_1000;
  localparam AluOpBus EXE_MULTU_OP = 8'b0001_1001;
  localparam AluOpBus EXE_MADD_OP  = 8'b1010_0110;
  localparam AluOpBus EXE_MADDU_OP = 8'b1010_1000;
  localparam AluOpBus EXE_MSUB_OP  = 8'b1010_1010;
  localparam AluOpBus EXE_MSUBU_OP = 8'b1010_1011;
  localparam AluOpBus EXE_DIV_OP   = 8'b0001_1010;
  localparam AluOpBus EXE_DIVU_OP  = 8'b0001_1011;

  function automatic RegBus abs_if(input logic take_abs, input RegBus v);
    return (take_abs && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ex_muldiv_div_radix2.sv
// ----------------------------------------------------------------------------
// div_radix2 : unsigned 32-step radix-2 restoring divider core
// Revision   : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module div_radix2
  import ex_muldiv_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  start_i,
  input  logic  annul_i,
  input  RegBus dividend_i,
  input  RegBus divisor_i,
  output logic  last_o,
  output RegBus quot_o,
  output RegBus rem_o
);

  // sr_q holds the partial remainder pre-shifted by one bit while running,
  // and the plain {remainder, quotient} pair once the final step lands.
  logic [64:0] sr_q, sr_d;
  RegBus       dvs_q, dvs_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        run_q, run_d;

  logic        w_ge;
  logic [32:0] w_rem;

  assign w_ge  = (sr_q[64:32] >= {1'b0, dvs_q});
  assign w_rem = w_ge ? (sr_q[64:32] - {1'b0, dvs_q}) : sr_q[64:32];

  always_comb begin
    sr_d  = sr_q;
    dvs_d = dvs_q;
    cnt_d = cnt_q;
    run_d = run_q;
    if (annul_i) begin
      run_d = 1'b0;
      cnt_d = 5'd0;
    end else if (start_i) begin
      dvs_d = divisor_i;
      cnt_d = 5'd0;
      run_d = (divisor_i != 32'd0);
      sr_d  = (divisor_i == 32'd0) ? 65'd0 : {32'd0, dividend_i, 1'b0};
    end else if (run_q) begin
      cnt_d = cnt_q + 5'd1;
      if (cnt_q == 5'd31) begin
        run_d = 1'b0;
        sr_d  = {w_rem, sr_q[31:1], w_ge};
      end else begin
        sr_d  = {w_rem[31:0], sr_q[31:1], w_ge, 1'b0};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q  <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      sr_q  <= sr_d;
      dvs_q <= dvs_d;
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end

  assign last_o = run_q && !annul_i && (cnt_q == 5'd31);
  assign quot_o = sr_q[31:0];
  assign rem_o  = sr_q[63:32];

endmodule

`default_nettype wire

// File: rtl/ex_muldiv.sv
// ----------------------------------------------------------------------------
// ex_muldiv : EX-stage multiply / multiply-accumulate / divide unit
// Revision  : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module ex_muldiv
  import ex_muldiv_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  AluOpBus aluop_i,
  input  RegBus   reg1_i,
  input  RegBus   reg2_i,
  input  RegBus   hi_i,
  input  RegBus   lo_i,
  input  logic    annul_i,
  output logic    stallreq_o,
  output logic    whilo_o,
  output RegBus   hi_o,
  output RegBus   lo_o
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_MACC     = 2'd1,
    S_DIV_RUN  = 2'd2,
    S_DIV_DONE = 2'd3
  } state_e;

  state_e      state_q, state_d;
  DoubleRegBus prod_q, prod_d;
  logic        msub_q, msub_d;
  logic        qneg_q, qneg_d;
  logic        rneg_q, rneg_d;

  logic        w_is_mul, w_is_macc, w_is_sub, w_is_div;
  logic        w_mul_signed, w_div_signed;
  DoubleRegBus w_opa, w_opb, w_product, w_acc;
  RegBus       w_dvd, w_dvs, w_quot, w_rem;
  logic        w_div_start, w_div_last;

  assign w_is_mul     = (aluop_i == EXE_MULT_OP) || (aluop_i == EXE_MULTU_OP);
  assign w_is_sub     = (aluop_i == EXE_MSUB_OP) || (aluop_i == EXE_MSUBU_OP);
  assign w_is_macc    = w_is_sub || (aluop_i == EXE_MADD_OP) || (aluop_i == EXE_MADDU_OP);
  assign w_is_div     = (aluop_i == EXE_DIV_OP) || (aluop_i == EXE_DIVU_OP);
  assign w_div_signed = (aluop_i == EXE_DIV_OP);
  assign w_mul_signed = (aluop_i == EXE_MULT_OP) || (aluop_i == EXE_MADD_OP) ||
                        (aluop_i == EXE_MSUB_OP);

  // Sign-extending to 64 bits lets one multiplier serve both signednesses.
  assign w_opa     = {{32{w_mul_signed & reg1_i[31]}}, reg1_i};
  assign w_opb     = {{32{w_mul_signed & reg2_i[31]}}, reg2_i};
  assign w_product = w_opa * w_opb;
  assign w_acc     = {hi_i, lo_i};

  assign w_dvd = abs_if(w_div_signed, reg1_i);
  assign w_dvs = abs_if(w_div_signed, reg2_i);

  div_radix2 u_div (
    .clk        (clk),
    .rst        (rst),
    .start_i    (w_div_start),
    .annul_i    (annul_i),
    .dividend_i (w_dvd),
    .divisor_i  (w_dvs),
    .last_o     (w_div_last),
    .quot_o     (w_quot),
    .rem_o      (w_rem)
  );

  always_comb begin
    state_d     = state_q;
    prod_d      = prod_q;
    msub_d      = msub_q;
    qneg_d      = qneg_q;
    rneg_d      = rneg_q;
    w_div_start = 1'b0;
    stallreq_o  = NoStop;
    whilo_o     = 1'b0;
    {hi_o, lo_o} = 64'd0;

    case (state_q)
      S_IDLE: begin
        if (w_is_mul) begin
          whilo_o      = 1'b1;
          {hi_o, lo_o} = w_product;
        end else if (w_is_macc) begin
          stallreq_o = Stop;
          prod_d     = w_product;
          msub_d     = w_is_sub;
          state_d    = S_MACC;
        end else if (w_is_div) begin
          stallreq_o  = Stop;
          w_div_start = 1'b1;
          qneg_d      = w_div_signed & (reg1_i[31] ^ reg2_i[31]);
          rneg_d      = w_div_signed & reg1_i[31];
          state_d     = (reg2_i == 32'd0) ? S_DIV_DONE : S_DIV_RUN;
        end
      end
      S_MACC: begin
        whilo_o      = 1'b1;
        {hi_o, lo_o} = msub_q ? (w_acc - prod_q) : (w_acc + prod_q);
        state_d      = S_IDLE;
      end
      S_DIV_RUN: begin
        stallreq_o = Stop;
        if (w_div_last) state_d = S_DIV_DONE;
      end
      S_DIV_DONE: begin
        whilo_o = 1'b1;
        lo_o    = qneg_q ? (~w_quot + 32'd1) : w_quot;
        hi_o    = rneg_q ? (~w_rem + 32'd1) : w_rem;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (annul_i || rst == RstEnable) begin
      stallreq_o   = NoStop;
      whilo_o      = 1'b0;
      {hi_o, lo_o} = 64'd0;
      w_div_start  = 1'b0;
      state_d      = S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state_q <= S_IDLE;
      prod_q  <= '0;
      msub_q  <= 1'b0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      prod_q  <= prod_d;
      msub_q  <= msub_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
    end
  end

endmodule

`default_nettype wire
